// File: rtl/mm_residual_add_if.sv
// Stream bundle for the residual-add stage: engine (mm) input, residual input and result output.
// The stage itself takes the slave view; whoever drives the inputs and sinks the result takes the master view.
interface mm_residual_add_if #(
   parameter int A_size     = 16,
   parameter int data_width = 8
);
   localparam int BW = A_size * data_width;

   logic          in_mm_valid;
   logic          in_mm_ready;
   logic          in_mm_last;
   logic [BW-1:0] in_mm_data;

   logic          in_res_valid;
   logic          in_res_ready;
   logic          in_res_last;
   logic [BW-1:0] in_res_data;

   logic          out_data_valid;
   logic          out_data_ready;
   logic          out_data_last;
   logic [BW-1:0] out_data;

   modport slave (
      input  in_mm_valid, in_mm_last, in_mm_data,
      input  in_res_valid, in_res_last, in_res_data,
      input  out_data_ready,
      output in_mm_ready, in_res_ready,
      output out_data_valid, out_data_last, out_data
   );

   modport master (
      output in_mm_valid, in_mm_last, in_mm_data,
      output in_res_valid, in_res_last, in_res_data,
      output out_data_ready,
      input  in_mm_ready, in_res_ready,
      input  out_data_valid, out_data_last, out_data
   );
endinterface

// File: rtl/mm_residual_add.sv
// Joins the matmul engine output with a residual stream, adds lane-wise with signed saturation,
// and regenerates the frame 'last' flag from a beat counter.
//  state | meaning
//  IDLE  | waiting for the first beat of a frame; config is taken from the input pins
//  RUN   | mid-frame; config comes from the values latched on the first beat
module mm_residual_add #(
   parameter int A_size                  = 16,
   parameter int data_width              = 8,
   parameter int F_length_width          = 9,
   parameter int W_width_block_num_width = 5
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic [F_length_width-1:0]          F_length_in,
   input  logic [W_width_block_num_width-1:0] W_width_block_num_in,
   input  logic                               bypass_in,
   mm_residual_add_if.slave                   bus,
   output logic                               frame_err,
   output logic                               busy
);
   localparam int BW = A_size * data_width;
   localparam int TW = F_length_width + W_width_block_num_width;

   typedef enum logic {IDLE, RUN} state_t;

   state_t                state, state_nxt;
   logic [TW-1:0]         beat_cnt, beat_cnt_nxt;
   logic [TW-1:0]         total_lat, total_cur;
   logic                  byp_lat, byp_cur;
   logic                  accept_en, xfer, cnt_end, err_now;
   logic [BW-1:0]         sum_data;
   logic [data_width:0]   lane_sum;

   // While IDLE the pins describe the frame that is about to start; afterwards the latched copy rules.
   assign total_cur = (state == IDLE) ? TW'(F_length_in) * TW'(W_width_block_num_in) : total_lat;
   assign byp_cur   = (state == IDLE) ? bypass_in : byp_lat;

   assign accept_en        = !bus.out_data_valid | bus.out_data_ready;
   assign xfer             = accept_en & bus.in_mm_valid & (byp_cur | bus.in_res_valid);
   assign bus.in_mm_ready  = accept_en & (byp_cur | bus.in_res_valid);
   assign bus.in_res_ready = accept_en & bus.in_mm_valid & !byp_cur;

   // Frames of 0 or 1 beats end on every beat.
   assign cnt_end = (total_cur <= TW'(1)) | (beat_cnt == total_cur - TW'(1));
   assign err_now = (bus.in_mm_last != cnt_end)
                  | (!byp_cur & (bus.in_res_last != cnt_end))
                  | (total_cur == '0);

   assign busy = (state == RUN) | bus.out_data_valid;

   always_comb begin
      state_nxt    = state;
      beat_cnt_nxt = beat_cnt;
      if (xfer) begin
         if (cnt_end) begin
            state_nxt    = IDLE;
            beat_cnt_nxt = '0;
         end else begin
            state_nxt    = RUN;
            beat_cnt_nxt = beat_cnt + TW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         beat_cnt <= '0;
      end else begin
         state    <= state_nxt;
         beat_cnt <= beat_cnt_nxt;
      end
   end

   // Sign-extended 9-bit sum cannot wrap; overflow shows as disagreement of the top two bits.
   always_comb begin
      sum_data = '0;
      lane_sum = '0;
      for (int i = 0; i < A_size; i++) begin
         lane_sum = {bus.in_mm_data[i*data_width + data_width - 1], bus.in_mm_data[i*data_width +: data_width]}
                  + {bus.in_res_data[i*data_width + data_width - 1], bus.in_res_data[i*data_width +: data_width]};
         if (byp_cur)
            sum_data[i*data_width +: data_width] = bus.in_mm_data[i*data_width +: data_width];
         else if (lane_sum[data_width] != lane_sum[data_width-1])
            sum_data[i*data_width +: data_width] = lane_sum[data_width]
               ? {1'b1, {(data_width-1){1'b0}}}
               : {1'b0, {(data_width-1){1'b1}}};
         else
            sum_data[i*data_width +: data_width] = lane_sum[data_width-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         total_lat          <= '0;
         byp_lat            <= 1'b0;
         bus.out_data_valid <= 1'b0;
         bus.out_data_last  <= 1'b0;
         bus.out_data       <= '0;
         frame_err          <= 1'b0;
      end else begin
         if (xfer && state == IDLE) begin
            total_lat <= total_cur;
            byp_lat   <= bypass_in;
         end
         if (accept_en)
            bus.out_data_valid <= xfer;
         if (xfer) begin
            bus.out_data      <= sum_data;
            bus.out_data_last <= cnt_end;
            // First beat of a frame (IDLE) clears the sticky flag unless this beat itself errs.
            frame_err         <= err_now | (frame_err & (state == RUN));
         end
      end
   end
endmodule

// File: tb/tb_mm_residual_add.sv
// Randomized bench for mm_residual_add: frames are generated up front, expected results come from
// a per-lane integer model, and independent drivers/sink apply random gaps and back-pressure.
module tb_mm_residual_add;
   localparam int AS = 16;
   localparam int DW = 8;
   localparam int FW = 9;
   localparam int WW = 5;
   localparam int BW = AS * DW;

   typedef struct {
      logic [BW-1:0] mm;
      logic [BW-1:0] res;
      logic          mm_last;
      logic          res_last;
      logic [FW-1:0] f;
      logic [WW-1:0] w;
      logic          byp;
      logic          first;
   } beat_t;

   typedef struct {
      logic [BW-1:0] data;
      logic          last;
      logic          err;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [FW-1:0] f_len;
   logic [WW-1:0] w_num;
   logic          bypass;
   logic          frame_err, busy;

   int checks = 0;
   int errors = 0;
   int stall_pct = 0;
   bit done = 1'b0;
   bit nobyp_run = 1'b0;
   bit byp_run = 1'b0;

   beat_t mm_q[$];
   beat_t res_q[$];
   exp_t  exp_q[$];

   always #5 clk = ~clk;

   mm_residual_add_if #(.A_size(AS), .data_width(DW)) bus ();

   mm_residual_add #(
      .A_size(AS), .data_width(DW), .F_length_width(FW), .W_width_block_num_width(WW)
   ) dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .F_length_in          (f_len),
      .W_width_block_num_in (w_num),
      .bypass_in            (bypass),
      .bus                  (bus),
      .frame_err            (frame_err),
      .busy                 (busy)
   );

   task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [BW-1:0] ref_out(input logic [BW-1:0] a, input logic [BW-1:0] b, input bit byp);
      logic [BW-1:0] r;
      logic [DW-1:0] x, y;
      int s;
      r = '0;
      for (int l = 0; l < AS; l++) begin
         x = a[l*DW +: DW];
         y = b[l*DW +: DW];
         s = int'($signed(x)) + int'($signed(y));
         if (byp) s = int'($signed(x));
         else if (s > 127) s = 127;
         else if (s < -128) s = -128;
         r[l*DW +: DW] = s[DW-1:0];
      end
      return r;
   endfunction

   // mode 0: random lanes, 1: fixed lane pairs per beat, 2: mm lanes alternate 0x7F/0x80
   function automatic void gen_frame(input int f, input int w, input bit byp, input int mode,
                                     input int inj_mm, input int inj_res);
      int    pa[4] = '{100, -100, 3, -5};
      int    pb[4] = '{50, -50, 4, 2};
      int    total, n, ta, tb;
      logic  err, end_k;
      beat_t b;
      exp_t  e;
      total = f * w;
      n = (total <= 1) ? 1 : total;
      err = 1'b0;
      for (int k = 0; k < n; k++) begin
         end_k = (total <= 1) || (k == total - 1);
         b.first = (k == 0);
         b.f = FW'(f);
         b.w = WW'(w);
         b.byp = byp;
         for (int l = 0; l < AS; l++) begin
            ta = int'($urandom);
            tb = int'($urandom);
            if (mode == 1) begin
               ta = pa[k % 4];
               tb = pb[k % 4];
            end else if (mode == 2) begin
               ta = (l % 2 == 1) ? 32'h80 : 32'h7F;
            end
            b.mm[l*DW +: DW]  = ta[DW-1:0];
            b.res[l*DW +: DW] = tb[DW-1:0];
         end
         b.mm_last  = end_k ^ (k == inj_mm);
         b.res_last = end_k ^ (k == inj_res);
         err = err | (b.mm_last != end_k) | (!byp && (b.res_last != end_k)) | (total == 0);
         e.data = ref_out(b.mm, b.res, byp);
         e.last = end_k;
         e.err  = err;
         mm_q.push_back(b);
         if (!byp) res_q.push_back(b);
         exp_q.push_back(e);
      end
   endfunction

   task automatic mm_drv();
      beat_t b;
      logic  hs;
      int    n;
      while (mm_q.size() > 0) begin
         b = mm_q.pop_front();
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         if (b.first) begin
            f_len  = b.f;
            w_num  = b.w;
            bypass = b.byp;
         end
         bus.in_mm_valid = 1'b1;
         bus.in_mm_data  = b.mm;
         bus.in_mm_last  = b.mm_last;
         n = 0;
         hs = 1'b0;
         while (!hs && n < 300) begin
            @(negedge clk);
            hs = bus.in_mm_ready;
            @(posedge clk); #1;
            n++;
         end
         chk("mm_handshake", BW'(hs), BW'(1));
         if (!hs) mm_q.delete();
         bus.in_mm_valid = 1'b0;
         bus.in_mm_last  = 1'b0;
         if (b.first) begin
            // Config pins wander mid-frame; the stage must ignore them until the next frame.
            f_len  = FW'($urandom);
            w_num  = WW'($urandom);
            bypass = 1'($urandom);
         end
      end
   endtask

   task automatic res_drv();
      beat_t b;
      logic  hs;
      int    n;
      while (res_q.size() > 0) begin
         b = res_q.pop_front();
         repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
         bus.in_res_valid = 1'b1;
         bus.in_res_data  = b.res;
         bus.in_res_last  = b.res_last;
         n = 0;
         hs = 1'b0;
         while (!hs && n < 300) begin
            @(negedge clk);
            hs = bus.in_res_ready;
            @(posedge clk); #1;
            n++;
         end
         chk("res_handshake", BW'(hs), BW'(1));
         if (!hs) res_q.delete();
         bus.in_res_valid = 1'b0;
         bus.in_res_last  = 1'b0;
      end
   endtask

   task automatic rdy_drv();
      while (!done) begin
         @(posedge clk); #1;
         bus.out_data_ready = ($urandom_range(0, 99) >= stall_pct);
      end
      bus.out_data_ready = 1'b1;
   endtask

   task automatic mon();
      exp_t          e;
      logic          pv, pl;
      logic [BW-1:0] pd;
      int            budget;
      pv = 1'b0;
      pl = 1'b0;
      pd = '0;
      budget = 200 + 20 * exp_q.size();
      while (exp_q.size() > 0 && budget > 0) begin
         @(negedge clk);
         budget--;
         if (pv) begin
            chk("hold_valid", BW'(bus.out_data_valid), BW'(1));
            chk("hold_data", bus.out_data, pd);
            chk("hold_last", BW'(bus.out_data_last), BW'(pl));
         end
         if (bus.out_data_valid) chk("busy_with_valid", BW'(busy), BW'(1));
         if (bus.out_data_valid && !bus.out_data_ready) begin
            chk("stall_mm_ready", BW'(bus.in_mm_ready), BW'(0));
            chk("stall_res_ready", BW'(bus.in_res_ready), BW'(0));
         end
         if (!bus.in_mm_valid) chk("res_ready_without_mm", BW'(bus.in_res_ready), BW'(0));
         if (nobyp_run && bus.in_mm_valid && !bus.in_res_valid)
            chk("mm_ready_without_res", BW'(bus.in_mm_ready), BW'(0));
         if (byp_run) chk("bypass_res_ready", BW'(bus.in_res_ready), BW'(0));
         if (bus.out_data_valid && bus.out_data_ready) begin
            e = exp_q.pop_front();
            chk("out_data", bus.out_data, e.data);
            chk("out_last", BW'(bus.out_data_last), BW'(e.last));
            chk("frame_err", BW'(frame_err), BW'(e.err));
         end
         pv = bus.out_data_valid && !bus.out_data_ready;
         pd = bus.out_data;
         pl = bus.out_data_last;
      end
      chk("all_beats_out", BW'(exp_q.size()), BW'(0));
      exp_q.delete();
      done = 1'b1;
   endtask

   task automatic run_phase();
      done = 1'b0;
      fork
         mm_drv();
         res_drv();
         rdy_drv();
         mon();
      join
      repeat (3) @(posedge clk);
      #1;
      chk("idle_busy", BW'(busy), BW'(0));
      chk("idle_valid", BW'(bus.out_data_valid), BW'(0));
   endtask

   initial begin
      int f, w;
      bit b;
      bus.in_mm_valid = 1'b0;
      bus.in_mm_last = 1'b0;
      bus.in_mm_data = '0;
      bus.in_res_valid = 1'b0;
      bus.in_res_last = 1'b0;
      bus.in_res_data = '0;
      bus.out_data_ready = 1'b1;
      f_len = '0;
      w_num = '0;
      bypass = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      chk("reset_valid", BW'(bus.out_data_valid), BW'(0));
      chk("reset_last", BW'(bus.out_data_last), BW'(0));
      chk("reset_data", bus.out_data, '0);
      chk("reset_err", BW'(frame_err), BW'(0));
      chk("reset_busy", BW'(busy), BW'(0));
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Saturating pairs, free-flowing then under back-pressure.
      nobyp_run = 1'b1;
      stall_pct = 0;
      gen_frame(2, 2, 1'b0, 1, -1, -1);
      run_phase();
      stall_pct = 50;
      gen_frame(2, 2, 1'b0, 1, -1, -1);
      run_phase();

      // Early mm last on beat 3, then a clean frame, then a bad residual last.
      stall_pct = 20;
      gen_frame(2, 2, 1'b0, 0, 2, -1);
      gen_frame(2, 2, 1'b0, 0, -1, -1);
      gen_frame(1, 4, 1'b0, 0, -1, 1);
      run_phase();
      nobyp_run = 1'b0;

      // Bypass with extreme lane values.
      byp_run = 1'b1;
      gen_frame(2, 3, 1'b1, 2, -1, -1);
      gen_frame(1, 1, 1'b1, 2, -1, -1);
      run_phase();
      byp_run = 1'b0;

      // Random frames, including zero-length and single-beat ones.
      stall_pct = 30;
      repeat (30) begin
         f = int'($urandom_range(1, 3));
         w = int'($urandom_range(0, 3));
         b = ($urandom_range(0, 9) < 3);
         gen_frame(f, w, b, 0,
                   ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 8)) : -1,
                   ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 8)) : -1);
      end
      run_phase();

      // Reset in the middle of a 6-beat frame.
      f_len = 9'd3;
      w_num = 5'd2;
      bypass = 1'b0;
      bus.out_data_ready = 1'b1;
      bus.in_mm_valid = 1'b1;
      bus.in_res_valid = 1'b1;
      bus.in_mm_data = {AS{8'h11}};
      bus.in_res_data = {AS{8'h22}};
      bus.in_mm_last = 1'b1;
      bus.in_res_last = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("pre_reset_valid", BW'(bus.out_data_valid), BW'(1));
      chk("pre_reset_busy", BW'(busy), BW'(1));
      chk("pre_reset_err", BW'(frame_err), BW'(1));
      chk("pre_reset_data", bus.out_data, {AS{8'h33}});
      #2 rst_n = 1'b0;
      #1;
      chk("mid_reset_valid", BW'(bus.out_data_valid), BW'(0));
      chk("mid_reset_last", BW'(bus.out_data_last), BW'(0));
      chk("mid_reset_data", bus.out_data, '0);
      chk("mid_reset_err", BW'(frame_err), BW'(0));
      chk("mid_reset_busy", BW'(busy), BW'(0));
      bus.in_mm_valid = 1'b0;
      bus.in_res_valid = 1'b0;
      bus.in_mm_last = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      nobyp_run = 1'b1;
      stall_pct = 25;
      gen_frame(3, 2, 1'b0, 0, -1, -1);
      run_phase();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
